// File: rtl/ps2_scan_controller.sv
// PS/2 keyboard receiver: synchronizes the raw lines, frames 11-bit packets, folds
// E0/F0 prefixes into key events and queues them in a small valid/ready FIFO.
module ps2_scan_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 5000,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         Keyboard_clock,
  input  logic                         Keyboard_Data,
  output logic [7:0]                   key_code,
  output logic                         key_ext,
  output logic                         key_release,
  output logic                         key_valid,
  input  logic                         key_ready,
  output logic                         frame_error,
  output logic                         overflow,
  input  logic                         clear_flags,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

  logic [SYNC_STAGES-1:0] kclk_sync_q, kdat_sync_q;
  logic                   kclk_prev_q;
  logic                   fe, din;

  state_t        state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          byte_valid_q, byte_valid_d;
  logic          frame_error_q, frame_error_d;
  logic          frm_err, kbd_err;

  logic          pend_ext_q, pend_ext_d, pend_brk_q, pend_brk_d;
  logic          push_req, push, pop, full, ovf_set;

  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q;

  // Lines idle high, so the chain resets to 1 to avoid a spurious falling edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      kclk_sync_q <= '1;
      kdat_sync_q <= '1;
      kclk_prev_q <= 1'b1;
    end else begin
      kclk_sync_q <= {kclk_sync_q[SYNC_STAGES-2:0], Keyboard_clock};
      kdat_sync_q <= {kdat_sync_q[SYNC_STAGES-2:0], Keyboard_Data};
      kclk_prev_q <= kclk_sync_q[SYNC_STAGES-1];
    end
  end

  assign fe  = kclk_prev_q & ~kclk_sync_q[SYNC_STAGES-1];
  assign din = kdat_sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    byte_valid_d = 1'b0;
    frm_err      = 1'b0;
    tmo_d        = (state_q == ST_IDLE || fe) ? '0 : tmo_q + TW'(1);
    unique case (state_q)
      ST_IDLE: if (fe && !din) begin
        state_d   = ST_DATA;
        bit_cnt_d = '0;
      end
      ST_DATA: if (fe) begin
        shift_d   = {din, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'd7) state_d = ST_PARITY;
      end
      ST_PARITY: if (fe) begin
        par_d   = din;
        state_d = ST_STOP;
      end
      ST_STOP: if (fe) begin
        if (din && (^{shift_q, par_q})) byte_valid_d = 1'b1;
        else                            frm_err      = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort on the edge where the counter would reach TIMEOUT_CYCLES-1.
    if (state_q != ST_IDLE && !fe && tmo_q == TW'(TIMEOUT_CYCLES - 2)) begin
      state_d = ST_IDLE;
      frm_err = 1'b1;
    end
  end

  always_comb begin
    pend_ext_d = pend_ext_q;
    pend_brk_d = pend_brk_q;
    push_req   = 1'b0;
    kbd_err    = 1'b0;
    if (byte_valid_q) begin
      unique case (shift_q)
        8'hE0: pend_ext_d = 1'b1;
        8'hF0: pend_brk_d = 1'b1;
        8'h00, 8'hFF: begin
          kbd_err    = 1'b1;
          pend_ext_d = 1'b0;
          pend_brk_d = 1'b0;
        end
        default: begin
          push_req   = 1'b1;
          pend_ext_d = 1'b0;
          pend_brk_d = 1'b0;
        end
      endcase
    end
    frame_error_d = frm_err | kbd_err;
  end

  assign pop     = (count_q != '0) && key_ready;
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign push    = push_req && (!full || pop);
  assign ovf_set = push_req && full && !pop;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      par_q         <= 1'b0;
      tmo_q         <= '0;
      byte_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      pend_ext_q    <= 1'b0;
      pend_brk_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      par_q         <= par_d;
      tmo_q         <= tmo_d;
      byte_valid_q  <= byte_valid_d;
      frame_error_q <= frame_error_d;
      pend_ext_q    <= pend_ext_d;
      pend_brk_q    <= pend_brk_d;
      count_q       <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= {pend_ext_q, pend_brk_q, shift_q};
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (ovf_set)          overflow_q <= 1'b1;
      else if (clear_flags) overflow_q <= 1'b0;
    end
  end

  assign key_code    = mem_q[rd_ptr_q][7:0];
  assign key_release = mem_q[rd_ptr_q][8];
  assign key_ext     = mem_q[rd_ptr_q][9];
  assign key_valid   = (count_q != '0);
  assign fifo_count  = count_q;
  assign frame_error = frame_error_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_ps2_scan_controller.sv
// Randomized bench for ps2_scan_controller against a byte-level event/queue model.
module tb_ps2_scan_controller;

  localparam int unsigned TMO   = 300;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned SYNC  = 2;
  localparam int unsigned HP    = 10;

  logic       clock = 1'b0;
  logic       reset_n, kclk, kdat, key_ready, clear_flags;
  logic [7:0] key_code;
  logic       key_ext, key_release, key_valid, frame_error, overflow;
  logic [2:0] fifo_count;

  int unsigned n_checks = 0, n_fail = 0, ferr_seen = 0, exp_ferr = 0;
  logic [9:0]  mq[$];
  logic        m_ext = 1'b0, m_brk = 1'b0, m_ovf = 1'b0;

  ps2_scan_controller #(.TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clock(clock), .reset_n(reset_n), .Keyboard_clock(kclk), .Keyboard_Data(kdat),
    .key_code(key_code), .key_ext(key_ext), .key_release(key_release), .key_valid(key_valid),
    .key_ready(key_ready), .frame_error(frame_error), .overflow(overflow),
    .clear_flags(clear_flags), .fifo_count(fifo_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (frame_error === 1'b1) ferr_seen++;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".count"}, 32'(fifo_count), 32'(mq.size()));
    check({tag, ".valid"}, 32'(key_valid), 32'(mq.size() != 0));
    if (mq.size() > 0)
      check({tag, ".head"}, 32'({key_ext, key_release, key_code}), 32'(mq[0]));
    check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    check({tag, ".ferr_cnt"}, ferr_seen, exp_ferr);
  endtask

  // Byte-level reference: optional same-cycle pop, prefix folding, bounded queue.
  task automatic model_byte(input logic [7:0] b, input logic good, input logic popped);
    if (popped && mq.size() > 0) mq.delete(0);
    if (!good) exp_ferr++;
    else if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'h00 || b == 8'hFF) begin
      exp_ferr++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else begin
      if (mq.size() < DEPTH) mq.push_back({m_ext, m_brk, b});
      else                   m_ovf = 1'b1;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic fall(input logic d);
    @(negedge clock);
    kdat = d;
    repeat (HP) @(negedge clock);
    kclk = 1'b0;
  endtask

  task automatic rise();
    repeat (HP) @(negedge clock);
    kclk = 1'b1;
  endtask

  // mode 0: plain frame; 1: pop in the push cycle; 2: measure key_valid latency
  task automatic send_byte(input logic [7:0] b, input logic bad_par, input int unsigned mode);
    logic [10:0] fr;
    int unsigned c;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      fall(fr[i]);
      rise();
    end
    fall(fr[10]);
    if (mode == 1) begin
      repeat (SYNC + 1) @(posedge clock);
      @(negedge clock);
      if (mq.size() > 0)
        check("head_before_sync_pop", 32'({key_ext, key_release, key_code}), 32'(mq[0]));
      key_ready = 1'b1;
      @(negedge clock);
      key_ready = 1'b0;
    end else if (mode == 2) begin
      c = 0;
      while (key_valid !== 1'b1 && c < 50) begin
        @(negedge clock);
        c++;
      end
      check("key_valid_latency", c, SYNC + 2);
    end
    rise();
    repeat (6) @(negedge clock);
    model_byte(b, !bad_par, mode == 1);
  endtask

  task automatic do_pop();
    @(negedge clock);
    key_ready = 1'b1;
    @(negedge clock);
    key_ready = 1'b0;
    if (mq.size() > 0) mq.delete(0);
  endtask

  task automatic do_clear();
    @(negedge clock);
    clear_flags = 1'b1;
    @(negedge clock);
    clear_flags = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    kclk    = 1'b1;
    kdat    = 1'b1;
    repeat (3) @(negedge clock);
    check("rst.key_code", 32'(key_code), 32'h0);
    check("rst.key_ext", 32'(key_ext), 32'h0);
    check("rst.key_release", 32'(key_release), 32'h0);
    check("rst.key_valid", 32'(key_valid), 32'h0);
    check("rst.frame_error", 32'(frame_error), 32'h0);
    check("rst.overflow", 32'(overflow), 32'h0);
    check("rst.fifo_count", 32'(fifo_count), 32'h0);
    reset_n = 1'b1;
    mq.delete();
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_ovf = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    logic [7:0]  b, part;
    logic        bp;
    int unsigned r, s, md, c;

    reset_n = 1'b0; kclk = 1'b1; kdat = 1'b1; key_ready = 1'b0; clear_flags = 1'b0;
    do_reset();

    send_byte(8'h1C, 1'b0, 2);
    check_state("make");
    do_pop();
    check_state("make_pop");

    send_byte(8'hF0, 1'b0, 0);
    send_byte(8'h1C, 1'b0, 0);
    send_byte(8'hE0, 1'b0, 0);
    send_byte(8'hF0, 1'b0, 0);
    send_byte(8'h75, 1'b0, 0);
    check_state("break_ext");
    do_pop();
    check_state("break_ext_pop1");
    do_pop();
    check_state("break_ext_pop2");

    send_byte(8'h1C, 1'b1, 0);
    check_state("parity_err");
    send_byte(8'h32, 1'b0, 0);
    check_state("after_parity");
    do_pop();

    part = 8'h5A;
    fall(1'b0);
    rise();
    for (int i = 0; i < 3; i++) begin
      fall(part[i]);
      rise();
    end
    fall(part[3]);
    c = 0;
    while (frame_error !== 1'b1 && c < TMO + 100) begin
      @(negedge clock);
      c++;
      if (c == HP) kclk = 1'b1;
    end
    check("timeout_latency", c, SYNC + TMO);
    exp_ferr++;
    repeat (5) @(negedge clock);
    check_state("timeout");
    send_byte(8'h1C, 1'b0, 0);
    check_state("after_timeout");
    do_pop();

    send_byte(8'h1C, 1'b0, 0);
    send_byte(8'h32, 1'b0, 0);
    send_byte(8'h21, 1'b0, 0);
    send_byte(8'h23, 1'b0, 0);
    send_byte(8'h24, 1'b0, 0);
    check_state("overflow");
    for (int i = 0; i < 4; i++) begin
      do_pop();
      check_state("ovf_drain");
    end
    do_clear();
    check_state("ovf_clear");
    send_byte(8'h1C, 1'b0, 0);
    send_byte(8'h32, 1'b0, 0);
    send_byte(8'h21, 1'b0, 0);
    send_byte(8'h23, 1'b0, 0);
    send_byte(8'h2B, 1'b0, 1);
    check_state("full_push_pop");
    do_clear();
    check_state("clear2");
    for (int i = 0; i < 4; i++) do_pop();
    check_state("drained");

    part = 8'hA7;
    fall(1'b0);
    rise();
    for (int i = 0; i < 5; i++) begin
      fall(part[i]);
      rise();
    end
    do_reset();
    send_byte(8'h1C, 1'b0, 0);
    check_state("after_reset");
    do_pop();

    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        s = $urandom_range(0, 11);
        if (s == 0)      b = 8'hE0;
        else if (s == 1) b = 8'hF0;
        else if (s == 2) b = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
        else begin
          b = 8'($urandom_range(1, 254));
          if (b == 8'hE0 || b == 8'hF0) b = 8'h1C;
        end
        bp = ($urandom_range(0, 7) == 0);
        md = ($urandom_range(0, 3) == 0) ? 1 : 0;
        send_byte(b, bp, md);
      end else if (r < 9) begin
        do_pop();
      end else begin
        do_clear();
      end
      check_state("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_scan_controller.md
Name: ps2_scan_controller

Overview:
- System-clock-domain controller for the PS/2 keyboard input path.
- Oversamples the raw Keyboard_clock/Keyboard_Data lines and frames 11-bit PS/2 packets with start, parity and stop checks plus an inactivity timeout.
- Folds E0 (extended) and F0 (break) prefixes into single key events.
- Buffers events in a small FIFO with a valid/ready handshake toward the decode/CPU side, so no scan code is lost while the consumer is busy.

Parameters:
- TIMEOUT_CYCLES, 5000, clock cycles allowed between PS/2 falling edges inside a frame before abort (100 us at 50 MHz).
- FIFO_DEPTH, 4, event FIFO entries; power of 2, minimum 2.
- SYNC_STAGES, 2, flip-flop stages on each PS/2 input line; minimum 2.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  synchronous reset, active low.
- Keyboard_clock  in  1  raw PS/2 clock line, asynchronous.
- Keyboard_Data  in  1  raw PS/2 data line, asynchronous.
- key_code  out  8  scan code of the event at the FIFO head.
- key_ext  out  1  head event was E0-prefixed.
- key_release  out  1  head event was F0-prefixed (break).
- key_valid  out  1  FIFO non-empty; head fields stable while high.
- key_ready  in  1  consumer accepts the head event.
- frame_error  out  1  one-cycle pulse on parity, start, stop, timeout or keyboard-error fault.
- overflow  out  1  sticky; an event was dropped because the FIFO was full.
- clear_flags  in  1  clears overflow.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current number of FIFO entries.

Behaviour:
- Reset (reset_n=0 at a rising clock edge): all outputs 0, frame FSM to IDLE, bit counter/shift register/timeout counter 0, pending_ext=pending_brk=0, FIFO emptied. Reset mid-frame discards the partial frame.
- Input sync: each line passes through SYNC_STAGES flops. A PS/2 falling edge (fe) is prev_sync_clk=1 and sync_clk=0, one cycle wide. All line sampling uses the synchronized data at fe.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
- IDLE: on fe with data=0, go to DATA and clear bit_cnt. On fe with data=1, stay in IDLE (glitch ignored).
- DATA: on fe, shift data in LSB first and increment bit_cnt. After the 8th bit, go to PARITY.
- PARITY: on fe, store the bit and go to STOP.
- STOP: on fe, the frame is good if data=1 and the XOR of the 8 data bits and the parity bit is 1 (odd parity). Good frame: byte_valid pulses for one cycle, then IDLE. Bad frame: frame_error pulses, then IDLE.
- Timeout: the counter clears on every fe and in IDLE. In DATA, PARITY or STOP, reaching TIMEOUT_CYCLES-1 without an fe pulses frame_error and forces IDLE.
- Prefix decode on byte_valid:
  - 0xE0: set pending_ext.
  - 0xF0: set pending_brk.
  - 0x00 or 0xFF: keyboard error/overrun; pulse frame_error, clear both pending flags, push nothing.
  - Any other byte: push {pending_ext, pending_brk, byte}, then clear both pending flags.
- Prefix state survives a frame error. The next non-prefix byte consumes it.
- FIFO: pop when key_valid && key_ready. Head fields drive key_code/key_ext/key_release combinationally from storage.
- Push while full:
  - With a pop in the same cycle: the push is accepted and count stays FIFO_DEPTH.
  - Without a pop: the event is dropped and overflow is set.
- Push and pop in the same non-full cycle leave count unchanged.
- Read/write pointers wrap modulo FIFO_DEPTH.
- overflow: set takes priority over clear_flags in the same cycle; otherwise clear_flags clears it.
- Latency: the fe that samples the stop bit is cycle N. byte_valid is high in cycle N+1. The FIFO write occurs at the end of N+1. key_valid is high in N+2 (FIFO previously empty).
- key_ready while key_valid=0 has no effect. Outputs are unchanged when no push or pop occurs.

Test Plan:
- Single make code: frame 0x1C, good parity -> exactly one event {code=0x1C, ext=0, release=0}; key_valid rises 2 cycles after the stop-bit fe; pulse key_ready -> fifo_count 1->0.
- Break and extended release: bytes F0,1C then E0,F0,75 -> two events in order: {1C,0,1} then {75,1,1}; no events for the prefix bytes.
- Parity error: frame 0x1C with even parity -> frame_error one-cycle pulse, fifo_count stays 0; a following good 0x32 frame -> event {32,0,0}.
- Timeout resync: start bit plus 4 data bits, then line idle -> frame_error exactly TIMEOUT_CYCLES cycles after the last fe, FSM in IDLE; a following full 0x1C frame decodes correctly.
- Overflow: key_ready=0, send 1C,32,21,23,24 -> fifo_count=4, overflow=1, pops return 1C,32,21,23. Then refill to full, send 2B in the same cycle key_ready=1 pops -> count stays 4, no new overflow. Assert clear_flags -> overflow=0.
- Reset mid-frame: assert reset_n=0 after 5 data bits -> all outputs 0; a subsequent complete 0x1C frame yields one correct event.
